// File: rtl/keypad_code_capture_pkg.sv
// Shared definitions for the keypad code capture front end of the `lock` comparator.
// Holds the digit width, entry length, FSM encoding and the one-hot helper.
package keypad_code_capture_pkg;

    localparam int DIGIT_W    = 10;
    localparam int NUM_DIGITS = 4;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CHECK   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot(input logic [DIGIT_W-1:0] v);
        return (v != '0) && ((v & (v - DIGIT_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/keypad_code_capture_key_press_detect.sv
// Press-edge detector for the keypad bus: one strobe per key-down,
// classified as a valid single digit or a multi-key chord.
module key_press_detect
    import keypad_code_capture_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] i_key,
    output logic               o_press,
    output logic               o_press_ok,
    output logic               o_press_bad
);

    logic [DIGIT_W-1:0] r_key_q;
    logic               w_onehot;

    // Tracks in every FSM state so a key held across CHECK never re-fires.
    always_ff @(posedge clk) begin
        if (rst) r_key_q <= '0;
        else     r_key_q <= i_key;
    end

    assign w_onehot    = is_onehot(i_key);
    assign o_press     = (i_key != '0) && (r_key_q == '0);
    assign o_press_ok  = o_press && w_onehot;
    assign o_press_bad = o_press && !w_onehot;

endmodule

// File: rtl/keypad_code_capture.sv
// Captures four keypad digits, presents them to `lock` for one CHECK cycle,
// and enforces entry timeout and a timed lockout after repeated failures.
module keypad_code_capture
    import keypad_code_capture_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 5000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] key_i,
    input  logic               clear_i,
    input  logic               locki,
    output logic [DIGIT_W-1:0] a1,
    output logic [DIGIT_W-1:0] a2,
    output logic [DIGIT_W-1:0] a3,
    output logic [DIGIT_W-1:0] a4,
    output logic [CNT_W-1:0]   entry_cnt,
    output logic               code_vld,
    output logic               granted,
    output logic               denied,
    output logic               key_err,
    output logic               timeout,
    output logic               lockout
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYC - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_DIGITS - 1);

    logic w_press, w_press_ok, w_press_bad;

    key_press_detect u_kpd (
        .clk         (clk),
        .rst         (rst),
        .i_key       (key_i),
        .o_press     (w_press),
        .o_press_ok  (w_press_ok),
        .o_press_bad (w_press_bad)
    );

    state_t                             r_state;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_dig;
    logic [CNT_W-1:0]                   r_cnt;
    logic [IDLE_W-1:0]                  r_idle;
    logic [LOCK_W-1:0]                  r_lock_cnt;
    logic [FAIL_W-1:0]                  r_fail;
    logic r_code_vld, r_granted, r_denied, r_key_err, r_timeout, r_lockout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_COLLECT;
            r_dig      <= '0;
            r_cnt      <= '0;
            r_idle     <= '0;
            r_lock_cnt <= '0;
            r_fail     <= '0;
            r_code_vld <= 1'b0;
            r_granted  <= 1'b0;
            r_denied   <= 1'b0;
            r_key_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_code_vld <= 1'b0;
            r_granted  <= 1'b0;
            r_denied   <= 1'b0;
            r_key_err  <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    // Clear outranks any press or timeout in the same cycle.
                    if (clear_i) begin
                        r_dig  <= '0;
                        r_cnt  <= '0;
                        r_idle <= '0;
                    end else if (w_press) begin
                        r_idle <= '0;
                        if (w_press_ok) begin
                            r_dig[r_cnt[1:0]] <= key_i;
                            r_cnt             <= r_cnt + CNT_W'(1);
                            if (r_cnt == CNT_LAST) begin
                                r_state    <= ST_CHECK;
                                r_code_vld <= 1'b1;
                            end
                        end else if (w_press_bad) begin
                            r_key_err <= 1'b1;
                        end
                    end else if (r_cnt != '0) begin
                        if (r_idle == IDLE_LAST) begin
                            r_dig     <= '0;
                            r_cnt     <= '0;
                            r_idle    <= '0;
                            r_timeout <= 1'b1;
                        end else begin
                            r_idle <= r_idle + IDLE_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    r_dig  <= '0;
                    r_cnt  <= '0;
                    r_idle <= '0;
                    r_state <= ST_COLLECT;
                    if (locki) begin
                        r_granted <= 1'b1;
                        r_fail    <= '0;
                    end else begin
                        r_denied <= 1'b1;
                        if (r_fail >= FAIL_LAST) begin
                            r_fail     <= FAIL_MAX;
                            r_state    <= ST_LOCKOUT;
                            r_lockout  <= 1'b1;
                            r_lock_cnt <= '0;
                        end else begin
                            r_fail <= r_fail + FAIL_W'(1);
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (r_lock_cnt == LOCK_LAST) begin
                        r_lock_cnt <= '0;
                        r_fail     <= '0;
                        r_lockout  <= 1'b0;
                        r_state    <= ST_COLLECT;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    assign a1        = r_dig[0];
    assign a2        = r_dig[1];
    assign a3        = r_dig[2];
    assign a4        = r_dig[3];
    assign entry_cnt = r_cnt;
    assign code_vld  = r_code_vld;
    assign granted   = r_granted;
    assign denied    = r_denied;
    assign key_err   = r_key_err;
    assign timeout   = r_timeout;
    assign lockout   = r_lockout;

endmodule

// File: tb/tb_keypad_code_capture.sv
// Directed bench for keypad_code_capture with shortened timeout/lockout periods.
module tb_keypad_code_capture;

    localparam int TO_CYC = 40;
    localparam int MF     = 3;
    localparam int LO_CYC = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] key_i = '0;
    logic       clear_i = 1'b0;
    logic       locki = 1'b0;
    logic [9:0] a1, a2, a3, a4;
    logic [2:0] entry_cnt;
    logic code_vld, granted, denied, key_err, timeout, lockout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_denied = 0, n_keyerr = 0, n_lock = 0;

    keypad_code_capture #(.TIMEOUT_CYC(TO_CYC), .MAX_FAIL(MF), .LOCKOUT_CYC(LO_CYC)) dut (
        .clk(clk), .rst(rst), .key_i(key_i), .clear_i(clear_i), .locki(locki),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .entry_cnt(entry_cnt),
        .code_vld(code_vld), .granted(granted), .denied(denied),
        .key_err(key_err), .timeout(timeout), .lockout(lockout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (denied)  n_denied++;
        if (key_err) n_keyerr++;
        if (lockout) n_lock++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enter_digit(input logic [9:0] k);
        key_i = k;
        tick(3);
        key_i = '0;
        tick(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_checks++;
        if ({a1, a2, a3, a4, entry_cnt, code_vld, granted, denied, key_err, timeout, lockout} !== '0)
            $display("FAIL reset_outputs: got a=%0d,%0d,%0d,%0d cnt=%0d flags=%b, want all 0",
                     a1, a2, a3, a4, entry_cnt, {code_vld, granted, denied, key_err, timeout, lockout});
        else n_pass++;
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_grant();
        locki = 1'b1;
        enter_digit(10'd1);
        enter_digit(10'd512);
        enter_digit(10'd8);
        key_i = 10'd2;
        tick(1);
        n_checks++;
        if ({code_vld, entry_cnt, a1, a2, a3, a4} !== {1'b1, 3'd4, 10'd1, 10'd512, 10'd8, 10'd2})
            $display("FAIL grant_check_cycle: vld=%b cnt=%0d a=%0d,%0d,%0d,%0d want 1 4 1,512,8,2",
                     code_vld, entry_cnt, a1, a2, a3, a4);
        else n_pass++;
        tick(1);
        n_checks++;
        if ({code_vld, granted, denied, entry_cnt, a1, a4} !== {1'b0, 1'b1, 1'b0, 3'd0, 10'd0, 10'd0})
            $display("FAIL grant_result: vld=%b gr=%b dn=%b cnt=%0d a1=%0d a4=%0d want 0 1 0 0 0 0",
                     code_vld, granted, denied, entry_cnt, a1, a4);
        else n_pass++;
        // key 2 still held from the CHECK entry: must not register
        tick(2);
        n_checks++;
        if ({granted, entry_cnt} !== {1'b0, 3'd0})
            $display("FAIL grant_held_key: gr=%b cnt=%0d want 0 0", granted, entry_cnt);
        else n_pass++;
        key_i = '0;
        tick(2);
    endtask

    task automatic test_deny();
        locki = 1'b0;
        enter_digit(10'd4);
        enter_digit(10'd4);
        enter_digit(10'd4);
        key_i = 10'd4;
        tick(2);
        n_checks++;
        if ({granted, denied, lockout, entry_cnt} !== {1'b0, 1'b1, 1'b0, 3'd0})
            $display("FAIL deny_result: gr=%b dn=%b lo=%b cnt=%0d want 0 1 0 0",
                     granted, denied, lockout, entry_cnt);
        else n_pass++;
        key_i = '0;
        tick(2);
    endtask

    task automatic test_key_err();
        do_reset();
        enter_digit(10'd1);
        enter_digit(10'd2);
        key_i = 10'd36;
        tick(1);
        n_checks++;
        if ({key_err, entry_cnt} !== {1'b1, 3'd2})
            $display("FAIL keyerr_pulse: err=%b cnt=%0d want 1 2", key_err, entry_cnt);
        else n_pass++;
        tick(1);
        n_checks++;
        if (key_err !== 1'b0)
            $display("FAIL keyerr_width: err=%b want 0", key_err);
        else n_pass++;
        key_i = '0;
        tick(1);
        enter_digit(10'd64);
        n_checks++;
        if ({entry_cnt, a3} !== {3'd3, 10'd64})
            $display("FAIL keyerr_next_digit: cnt=%0d a3=%0d want 3 64", entry_cnt, a3);
        else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        key_i = 10'd256;
        tick(20);
        n_checks++;
        if ({entry_cnt, a1} !== {3'd1, 10'd256})
            $display("FAIL hold_single: cnt=%0d a1=%0d want 1 256", entry_cnt, a1);
        else n_pass++;
        key_i = '0;
        tick(1);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        enter_digit(10'd1);
        enter_digit(10'd2);
        // four idle edges already elapsed after the second press edge
        n = 4;
        while (timeout !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (n != TO_CYC)
            $display("FAIL timeout_delay: fired after %0d idle cycles want %0d", n, TO_CYC);
        else n_pass++;
        n_checks++;
        if ({entry_cnt, a1, a2} !== {3'd0, 10'd0, 10'd0})
            $display("FAIL timeout_clear: cnt=%0d a1=%0d a2=%0d want 0 0 0", entry_cnt, a1, a2);
        else n_pass++;
        tick(1);
        n_checks++;
        if (timeout !== 1'b0)
            $display("FAIL timeout_width: to=%b want 0", timeout);
        else n_pass++;
    endtask

    task automatic test_lockout();
        int n;
        do_reset();
        locki = 1'b0;
        n_denied = 0;
        n_keyerr = 0;
        n_lock = 0;
        repeat (MF) begin
            enter_digit(10'd1);
            enter_digit(10'd2);
            enter_digit(10'd4);
            enter_digit(10'd8);
        end
        n_checks++;
        if ({lockout, 32'(n_denied)} !== {1'b1, 32'(MF)})
            $display("FAIL lockout_entry: lo=%b denied=%0d want 1 %0d", lockout, n_denied, MF);
        else n_pass++;
        enter_digit(10'd16);
        key_i = 10'd3;
        clear_i = 1'b1;
        tick(2);
        key_i = '0;
        clear_i = 1'b0;
        tick(1);
        n_checks++;
        if ({entry_cnt, a1, 32'(n_keyerr)} !== {3'd0, 10'd0, 32'd0})
            $display("FAIL lockout_ignore: cnt=%0d a1=%0d keyerr=%0d want 0 0 0", entry_cnt, a1, n_keyerr);
        else n_pass++;
        n = 0;
        while (lockout === 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (n_lock != LO_CYC)
            $display("FAIL lockout_length: high %0d cycles want %0d", n_lock, LO_CYC);
        else n_pass++;
        enter_digit(10'd32);
        n_checks++;
        if ({entry_cnt, a1} !== {3'd1, 10'd32})
            $display("FAIL lockout_resume: cnt=%0d a1=%0d want 1 32", entry_cnt, a1);
        else n_pass++;
        // fail counter must restart at 0: one more wrong code does not lock
        enter_digit(10'd1);
        enter_digit(10'd1);
        enter_digit(10'd1);
        n_checks++;
        if ({lockout, 32'(n_denied)} !== {1'b0, 32'(MF + 1)})
            $display("FAIL lockout_fail_cleared: lo=%b denied=%0d want 0 %0d", lockout, n_denied, MF + 1);
        else n_pass++;
    endtask

    task automatic test_clear();
        do_reset();
        enter_digit(10'd1);
        enter_digit(10'd2);
        enter_digit(10'd4);
        key_i = 10'd8;
        clear_i = 1'b1;
        tick(1);
        n_checks++;
        if ({entry_cnt, a1, a3} !== {3'd0, 10'd0, 10'd0})
            $display("FAIL clear_wins: cnt=%0d a1=%0d a3=%0d want 0 0 0", entry_cnt, a1, a3);
        else n_pass++;
        clear_i = 1'b0;
        tick(2);
        n_checks++;
        if ({entry_cnt, a1} !== {3'd0, 10'd0})
            $display("FAIL clear_press_dropped: cnt=%0d a1=%0d want 0 0", entry_cnt, a1);
        else n_pass++;
        key_i = '0;
        tick(1);
        // clear asserted during CHECK must not disturb the result
        locki = 1'b1;
        enter_digit(10'd1);
        enter_digit(10'd2);
        enter_digit(10'd4);
        key_i = 10'd16;
        tick(1);
        clear_i = 1'b1;
        tick(1);
        n_checks++;
        if ({granted, entry_cnt} !== {1'b1, 3'd0})
            $display("FAIL clear_in_check: gr=%b cnt=%0d want 1 0", granted, entry_cnt);
        else n_pass++;
        clear_i = 1'b0;
        key_i = '0;
        tick(2);
    endtask

    task automatic test_rst_mid();
        enter_digit(10'd128);
        enter_digit(10'd256);
        rst = 1'b1;
        tick(1);
        n_checks++;
        if ({a1, a2, entry_cnt, code_vld, granted, denied, key_err, timeout, lockout} !== '0)
            $display("FAIL rst_mid_entry: a1=%0d a2=%0d cnt=%0d want 0 0 0", a1, a2, entry_cnt);
        else n_pass++;
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_grant();
        test_deny();
        test_key_err();
        test_hold();
        test_timeout();
        test_lockout();
        test_clear();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
